pio_host_ctrl: RTL and testbench
================================

PIO_HOST_CTRL -- requirements
Module: pio_host_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32, meaning the maximum instruction count per LOAD command; legal range 1..32.
REQ-002 SHALL have port clk, input, 1, system clock; all logic on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1, host command request.
REQ-005 SHALL have port cmd_ready, output, 1, controller idle and able to accept a command.
REQ-006 SHALL have port cmd_op, input, 4, PIO action code (1..10) to issue.
REQ-007 SHALL have port cmd_sm, input, 2, target state machine index.
REQ-008 SHALL have port cmd_addr, input, 5, instruction index or LOAD start address.
REQ-009 SHALL have port cmd_len, input, 6, LOAD instruction count.
REQ-010 SHALL have port cmd_data, input, 32, data word for single-cycle actions.
REQ-011 SHALL have port prog_rd, output, 1, program-store read strobe.
REQ-012 SHALL have port prog_addr, output, 5, program-store read address.
REQ-013 SHALL have port prog_data, input, 16, program-store data, valid the cycle after prog_rd.
REQ-014 SHALL have ports pio_mindex (output, 2), pio_index (output, 5), pio_din (output, 32), pio_action (output, 4): PIO command bus.
REQ-015 SHALL have port pio_dout, input, 32, PIO read data.
REQ-016 SHALL have ports rsp_valid (output, 1, one-cycle completion pulse), rsp_err (output, 1), rsp_data (output, 32).

Function
REQ-017 SHALL accept a command on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_ready=1 only in IDLE; all cmd_* fields latched at acceptance.
REQ-018 SHALL drive pio_action=0 in every cycle not listed below; the PIO bus carries at most one action per cycle.
REQ-019 SHALL implement states IDLE, LOAD, SINGLE, READ_WAIT, RESP.
REQ-020 Single ops (cmd_op 2,4,5,6,7,8,9,10): IDLE->SINGLE; in the cycle after acceptance, pio_action=cmd_op, pio_mindex=cmd_sm, pio_index=cmd_addr, pio_din=cmd_data for exactly one cycle; next cycle RESP.
REQ-021 READ (cmd_op 3): SINGLE issues action 3 for one cycle, then READ_WAIT for one cycle; rsp_data=pio_dout sampled at the end of READ_WAIT; then RESP.
REQ-022 LOAD (cmd_op 1): pipelined; for k=0..len-1, prog_rd=1 with prog_addr=(cmd_addr+k) mod 32 in cycle k+1 after acceptance; in cycle k+2, pio_action=1, pio_index=(cmd_addr+k) mod 32, pio_din={16'h0000, prog_data}, pio_mindex=cmd_sm.
REQ-023 LOAD SHALL sustain one instruction write per cycle; the last write occurs in cycle len+1; RESP follows in cycle len+2.
REQ-024 Addresses SHALL wrap modulo 32 (cmd_addr=30, len=4 writes 30,31,0,1).
REQ-025 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; rsp_data=0 for non-READ ops.
REQ-026 Illegal commands (cmd_op 0 or 11..15; LOAD with cmd_len=0 or cmd_len>MAX_LEN) SHALL issue no PIO action and no prog_rd, and go directly to RESP with rsp_err=1.
REQ-027 cmd_valid while busy SHALL be ignored (not queued); the host must hold it until cmd_ready.
REQ-028 Back-to-back commands: a new command SHALL be accepted no earlier than the cycle after the rsp_valid pulse.

Reset
REQ-029 Reset SHALL force IDLE; cmd_ready=1, pio_action=0, pio_mindex=0, pio_index=0, pio_din=0, prog_rd=0, prog_addr=0, rsp_valid=0, rsp_err=0, rsp_data=0 in the cycle after reset is sampled.
REQ-030 Reset mid-LOAD or mid-READ SHALL abort immediately: no further PIO actions and no rsp_valid for the aborted command.

Verification
REQ-031 LOAD sm=0, addr=0, len=3, store={16'hE001,16'h0000,16'hA0A0} -> actions 1 at index 0,1,2 in consecutive cycles with pio_din low halves matching; rsp_valid at cycle 5, rsp_err=0.
REQ-032 LOAD addr=30, len=4 -> pio_index sequence 30,31,0,1; prog_addr sequence identical.
REQ-033 READ sm=2 with pio_dout=32'hDEADBEEF at READ_WAIT -> one action 3 with pio_mindex=2; rsp_data=32'hDEADBEEF.
REQ-034 cmd_op=6, cmd_data=32'h0000000F -> single cycle pio_action=6, pio_din=32'hF; rsp_valid next cycle.
REQ-035 cmd_op=12, and LOAD len=0, and LOAD len=33 -> no PIO action, no prog_rd, rsp_err=1 each.
REQ-036 Reset asserted at cycle 2 of LOAD len=8 -> pio_action=0 thereafter, no rsp_valid, cmd_ready=1 after reset.

Source files
------------

// File: rtl/pio_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pio_host_ctrl
// Description : Host command front-end for a PIO block. It accepts one host
//               command at a time and turns it into PIO command-bus actions.
//               LOAD streams instructions from a program store into PIO
//               instruction memory at one write per cycle. Single-cycle
//               actions are issued directly. READ captures pio_dout one cycle
//               after the read action. Every command ends with a one-cycle
//               response pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset              : clock (rising edge); synchronous active-high reset
//   cmd_valid / cmd_ready   : host command handshake (ready only when idle)
//   cmd_op                  : PIO action code (1..10)
//   cmd_sm                  : target state machine index
//   cmd_addr                : instruction index, or LOAD start address
//   cmd_len                 : LOAD instruction count
//   cmd_data                : data word for single-cycle actions
//   prog_rd / prog_addr     : program-store read strobe and address
//   prog_data               : program-store data, valid the cycle after prog_rd
//   pio_mindex, pio_index,
//   pio_din, pio_action     : PIO command bus (action 0 means no action)
//   pio_dout                : PIO read data
//   rsp_valid/err/data      : one-cycle completion response
// ============================================================================
module pio_host_ctrl #(
  parameter int MAX_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [1:0]  cmd_sm,
  input  logic [4:0]  cmd_addr,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        prog_rd,
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [1:0]  pio_mindex,
  output logic [4:0]  pio_index,
  output logic [31:0] pio_din,
  output logic [3:0]  pio_action,
  input  logic [31:0] pio_dout,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_data
);

  localparam logic [5:0] c_MAX_LEN  = 6'(MAX_LEN);
  localparam logic [3:0] c_OP_LOAD  = 4'd1;
  localparam logic [3:0] c_OP_READ  = 4'd3;
  localparam logic [3:0] c_OP_LAST  = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SINGLE    = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  sm_q, sm_d;
  logic [4:0]  addr_q, addr_d;
  logic [5:0]  len_q, len_d;
  logic [31:0] data_q, data_d;
  logic [5:0]  rd_cnt_q, rd_cnt_d;     // program-store reads issued so far
  logic        wr_pend_q, wr_pend_d;   // prog_data this cycle must be written
  logic [4:0]  wr_idx_q, wr_idx_d;     // instruction index for that write
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        cmd_illegal;

  assign cmd_illegal = (cmd_op == 4'd0) || (cmd_op > c_OP_LAST) ||
                       ((cmd_op == c_OP_LOAD) &&
                        ((cmd_len == 6'd0) || (cmd_len > c_MAX_LEN)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= 4'd0;
      sm_q      <= 2'd0;
      addr_q    <= 5'd0;
      len_q     <= 6'd0;
      data_q    <= 32'd0;
      rd_cnt_q  <= 6'd0;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= 5'd0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sm_q      <= sm_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      data_q    <= data_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_pend_q <= wr_pend_d;
      wr_idx_q  <= wr_idx_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sm_d       = sm_q;
    addr_d     = addr_q;
    len_d      = len_q;
    data_d     = data_q;
    rd_cnt_d   = rd_cnt_q;
    wr_pend_d  = 1'b0;
    wr_idx_d   = wr_idx_q;
    err_d      = err_q;
    rdata_d    = rdata_q;

    cmd_ready  = (state_q == ST_IDLE);
    prog_rd    = 1'b0;
    // 5-bit sum gives the modulo-32 wrap of the instruction address for free
    prog_addr  = addr_q + rd_cnt_q[4:0];
    pio_action = 4'd0;
    pio_mindex = sm_q;
    pio_index  = addr_q;
    pio_din    = data_q;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_data   = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          sm_d     = cmd_sm;
          addr_d   = cmd_addr;
          len_d    = cmd_len;
          data_d   = cmd_data;
          rd_cnt_d = 6'd0;
          rdata_d  = 32'd0;
          err_d    = cmd_illegal;
          if (cmd_illegal)              state_d = ST_RESP;
          else if (cmd_op == c_OP_LOAD) state_d = ST_LOAD;
          else                          state_d = ST_SINGLE;
        end
      end

      // Two-stage pipeline: a read issued in one cycle is written the next,
      // so reads and writes overlap and one write completes every cycle.
      ST_LOAD: begin
        if (wr_pend_q) begin
          pio_action = c_OP_LOAD;
          pio_index  = wr_idx_q;
          pio_din    = {16'h0000, prog_data};
        end
        if (rd_cnt_q < len_q) begin
          prog_rd   = 1'b1;
          rd_cnt_d  = rd_cnt_q + 6'd1;
          wr_pend_d = 1'b1;
          wr_idx_d  = prog_addr;
        end else begin
          // all reads issued; this cycle carries the final write
          state_d = ST_RESP;
        end
      end

      ST_SINGLE: begin
        pio_action = op_q;
        state_d    = (op_q == c_OP_READ) ? ST_READ_WAIT : ST_RESP;
      end

      ST_READ_WAIT: begin
        rdata_d = pio_dout;
        state_d = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_data  = rdata_q;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pio_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_host_ctrl
// Description : Self-checking bench for pio_host_ctrl. Each command is
//               predicted as a timeline of expected bus activity per cycle
//               after acceptance and compared cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_host_ctrl;

  localparam int MAXL = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [1:0]  cmd_sm;
  logic [4:0]  cmd_addr;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        prog_rd;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  pio_mindex;
  logic [4:0]  pio_index;
  logic [31:0] pio_din;
  logic [3:0]  pio_action;
  logic [31:0] pio_dout;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_data;

  logic [15:0] mem [32];
  logic        dout_fix;
  int          n_cmp = 0;
  int          n_err = 0;

  pio_host_ctrl #(.MAX_LEN(MAXL)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sm(cmd_sm), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_data(cmd_data), .prog_rd(prog_rd), .prog_addr(prog_addr),
    .prog_data(prog_data), .pio_mindex(pio_mindex), .pio_index(pio_index),
    .pio_din(pio_din), .pio_action(pio_action), .pio_dout(pio_dout),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // program store: registered read, data valid the cycle after prog_rd
  always @(posedge clk) begin
    if (prog_rd) prog_data <= mem[prog_addr];
    pio_dout <= dout_fix ? 32'hDEADBEEF : $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Issue one command and check every cycle up to the first idle cycle after
  // the response, against a timeline derived from the command alone.
  task automatic run_cmd(input logic [3:0] op, input logic [1:0] sm,
                         input logic [4:0] addr, input logic [5:0] len,
                         input logic [31:0] data);
    bit          illegal;
    int          rsp_c;
    logic [3:0]  e_act;
    logic [4:0]  e_idx;
    logic [31:0] e_din;
    logic [31:0] e_rdata;
    bit          e_rd;
    illegal = (op == 0) || (op > 10) ||
              (op == 1 && (len == 0 || int'(len) > MAXL));
    if (illegal)      rsp_c = 1;
    else if (op == 1) rsp_c = int'(len) + 2;
    else if (op == 3) rsp_c = 3;
    else              rsp_c = 2;
    e_rdata = 32'd0;

    @(negedge clk);
    chk("ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_sm = sm;
    cmd_addr = addr; cmd_len = len; cmd_data = data;
    @(posedge clk);

    for (int c = 1; c <= rsp_c + 1; c++) begin
      @(negedge clk);
      e_act = 4'd0; e_idx = 5'd0; e_din = 32'd0;
      if (!illegal && op == 1 && c >= 2 && c <= int'(len) + 1) begin
        e_act = 4'd1;
        e_idx = addr + 5'(c - 2);
        e_din = {16'h0000, mem[e_idx]};
      end
      if (!illegal && op != 1 && c == 1) begin
        e_act = op; e_idx = addr; e_din = data;
      end
      e_rd = !illegal && op == 1 && c <= int'(len);

      chk("pio_action", {28'd0, pio_action}, {28'd0, e_act});
      if (e_act != 0) begin
        chk("pio_mindex", {30'd0, pio_mindex}, {30'd0, sm});
        chk("pio_index",  {27'd0, pio_index},  {27'd0, e_idx});
        chk("pio_din",    pio_din, e_din);
      end
      chk("prog_rd", {31'd0, prog_rd}, {31'd0, e_rd});
      if (e_rd) chk("prog_addr", {27'd0, prog_addr}, {27'd0, 5'(addr + 5'(c - 1))});
      if (op == 3 && !illegal && c == 2) e_rdata = pio_dout;
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, (c == rsp_c)});
      if (c == rsp_c) begin
        chk("rsp_err",  {31'd0, rsp_err}, {31'd0, illegal});
        chk("rsp_data", rsp_data, e_rdata);
      end
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, (c == rsp_c + 1)});

      // noise on the command port while busy must be ignored
      if (c < rsp_c) begin
        cmd_valid = 1'($urandom); cmd_op = 4'($urandom);
        cmd_sm = 2'($urandom); cmd_addr = 5'($urandom);
        cmd_len = 6'($urandom); cmd_data = $urandom;
      end else begin
        cmd_valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic [3:0] r_op;
    logic [5:0] r_len;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 0; cmd_sm = 0;
    cmd_addr = 0; cmd_len = 0; cmd_data = 0; dout_fix = 1'b0;
    prog_data = 16'h0;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  {31'd0, cmd_ready}, 32'd1);
    chk("rst_action", {28'd0, pio_action}, 32'd0);
    chk("rst_mindex", {30'd0, pio_mindex}, 32'd0);
    chk("rst_index",  {27'd0, pio_index}, 32'd0);
    chk("rst_din",    pio_din, 32'd0);
    chk("rst_prd",    {31'd0, prog_rd}, 32'd0);
    chk("rst_paddr",  {27'd0, prog_addr}, 32'd0);
    chk("rst_rsp",    {29'd0, rsp_valid, rsp_err, 1'b0}, 32'd0);
    chk("rst_rdata",  rsp_data, 32'd0);
    reset = 1'b0;

    // directed cases
    mem[0] = 16'hE001; mem[1] = 16'h0000; mem[2] = 16'hA0A0;
    run_cmd(4'd1, 2'd0, 5'd0, 6'd3, 32'd0);
    run_cmd(4'd1, 2'd1, 5'd30, 6'd4, 32'd0);
    dout_fix = 1'b1;
    run_cmd(4'd3, 2'd2, 5'd7, 6'd0, 32'd0);
    dout_fix = 1'b0;
    run_cmd(4'd6, 2'd0, 5'd3, 6'd0, 32'h0000000F);
    run_cmd(4'd12, 2'd1, 5'd4, 6'd2, 32'h1234);
    run_cmd(4'd1, 2'd0, 5'd0, 6'd0, 32'd0);
    run_cmd(4'd1, 2'd0, 5'd0, 6'd33, 32'd0);
    run_cmd(4'd1, 2'd3, 5'd5, 6'd32, 32'd0);

    // reset in the middle of a LOAD of length 8
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_sm = 2'd1; cmd_addr = 5'd9; cmd_len = 6'd8;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("abort_action", {28'd0, pio_action}, 32'd0);
      chk("abort_rsp",    {31'd0, rsp_valid}, 32'd0);
      chk("abort_prd",    {31'd0, prog_rd}, 32'd0);
      chk("abort_ready",  {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
    end

    // randomized commands
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      if ($urandom_range(0, 7) == 0) r_op = 4'($urandom);
      else                           r_op = 4'($urandom_range(1, 10));
      if ($urandom_range(0, 5) == 0) r_len = 6'($urandom);
      else                           r_len = 6'($urandom_range(1, MAXL));
      run_cmd(r_op, 2'($urandom), 5'($urandom), r_len, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
